// File: rtl/spart_tx_fifo.sv
// rtl/spart_tx_fifo.sv - FIFO-buffered serial transmitter, optional parity via SPART_TX_PARITY_EN
module spart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tx_begin,
    input  logic [DATA_BITS-1:0]          transmit_buffer,
    input  logic [DIV_W-1:0]              divisor_buffer,
    input  logic                          two_stop,
    input  logic                          parity_odd,
    output logic                          tbr,
    output logic                          tx_busy,
    output logic                          tx_ovf,
    output logic [$clog2(FIFO_DEPTH):0]   tx_count,
    output logic                          txd
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BITS_LD  = BW'(DATA_BITS);

`ifdef SPART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;
    logic                 r_ovf;
    state_t               r_state;
    state_t               w_state_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DIV_W-1:0]     r_baud;
    logic [DIV_W-1:0]     r_div;
    logic [BW-1:0]        r_bit_cnt;
    logic                 r_two_stop;
    logic                 r_stop_left;
    logic                 r_txd;
    logic                 w_txd_nxt;
    logic                 w_pop;
    logic                 w_push_ok;
    logic                 w_bit_end;
    logic [DATA_BITS-1:0] w_head;

`ifdef SPART_TX_PARITY_EN
    logic                 r_par;
`else
    logic                 w_unused_parity;
    assign w_unused_parity = parity_odd;
`endif

    assign w_head    = r_mem[r_rd_ptr];
    assign w_bit_end = (r_baud == '0);
    // A pop on this edge frees a slot, so a push into a full FIFO still lands
    assign w_push_ok = tx_begin && ((r_count != FULL_CNT) || w_pop);

    assign tbr      = (r_count != FULL_CNT);
    assign tx_busy  = (r_state != S_IDLE) || (r_count != '0);
    assign tx_ovf   = r_ovf;
    assign tx_count = r_count;
    assign txd      = r_txd;

    // FIFO storage write; contents need no reset because the pointers do
    always_ff @(posedge clk) begin
        if (w_push_ok && !rst)
            r_mem[r_wr_ptr] <= transmit_buffer;
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push_ok && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_push_ok && w_pop)
                r_count <= r_count - 1'b1;
            if (tx_begin && !w_push_ok)
                r_ovf <= 1'b1;
        end
    end

    // Next-state and next-txd; txd is registered so the pin never glitches
    always_comb begin
        w_state_nxt = r_state;
        w_txd_nxt   = r_txd;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_txd_nxt = 1'b1;
                if (r_count != '0)
                    w_pop = 1'b1;
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                    w_txd_nxt   = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == BW'(1)) begin
`ifdef SPART_TX_PARITY_EN
                        w_state_nxt = S_PARITY;
                        w_txd_nxt   = r_par;
`else
                        w_state_nxt = S_STOP;
                        w_txd_nxt   = 1'b1;
`endif
                    end else begin
                        w_txd_nxt = r_shift[1];
                    end
                end
            end
`ifdef SPART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                    w_txd_nxt   = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_end && !r_stop_left) begin
                    if (r_count != '0)
                        w_pop = 1'b1;
                    else
                        w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_txd_nxt   = 1'b1;
            end
        endcase
        if (w_pop) begin
            w_state_nxt = S_START;
            w_txd_nxt   = 1'b0;
        end
    end

    // State register plus frame datapath: latch settings at frame start, run baud/bit counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_txd       <= 1'b1;
            r_shift     <= '0;
            r_baud      <= '0;
            r_div       <= '0;
            r_bit_cnt   <= '0;
            r_two_stop  <= 1'b0;
            r_stop_left <= 1'b0;
`ifdef SPART_TX_PARITY_EN
            r_par       <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_txd   <= w_txd_nxt;
            if (w_pop) begin
                r_shift    <= w_head;
                r_div      <= divisor_buffer;
                r_baud     <= divisor_buffer;
                r_two_stop <= two_stop;
                r_bit_cnt  <= BITS_LD;
`ifdef SPART_TX_PARITY_EN
                r_par      <= (^w_head) ^ parity_odd;
`endif
            end else if (r_state != S_IDLE) begin
                if (w_bit_end) begin
                    r_baud <= r_div;
                    if (r_state == S_DATA) begin
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= r_bit_cnt - 1'b1;
                    end
                end else begin
                    r_baud <= r_baud - 1'b1;
                end
            end
            if (w_state_nxt == S_STOP && r_state != S_STOP)
                r_stop_left <= r_two_stop;
            else if (r_state == S_STOP && w_bit_end)
                r_stop_left <= 1'b0;
        end
    end
endmodule
